// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - two-stage valid/ready execute ALU with flags and saturating event counters
//
// Purpose:
//   Execute-stage ALU. Stage 1 latches the control code and operands on an input
//   transfer. Stage 2 holds the computed result and flags until downstream takes them.
//   Full backpressure: each stage may advance only when the stage after it can accept.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake; in_ctrl/in_a/in_b sampled on transfer
//   out_valid/out_ready downstream handshake; out_* stable while stalled
//   out_result          WIDTH-bit result (mod 2^WIDTH)
//   out_zero            out_result == 0
//   out_ovf             signed overflow (ADD / SUB only)
//   out_illegal         control code was undefined
//   op_count            delivered results (saturating)
//   ovf_count           delivered results that had out_ovf set (saturating)

module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ctrl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_ADDR = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Stage 1: operand latch
  logic             r_s1_valid;
  logic [3:0]       r_s1_ctrl;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  // Stage 2: result register
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_result;
  logic             r_s2_zero;
  logic             r_s2_ovf;
  logic             r_s2_illegal;

  logic [CNT_W-1:0] r_op_count;
  logic [CNT_W-1:0] r_ovf_count;

  // Handshake
  logic w_s2_ready;
  logic w_s1_ready;
  logic w_in_fire;
  logic w_s1_to_s2;
  logic w_out_fire;

  // Compute
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_a_msb;
  logic             w_b_msb;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic             w_slt;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_ill;
  logic             w_zero;

  // Ready chain looks only at downstream state, never at in_valid, so
  // upstream may legally make in_valid independent of in_ready.
  assign w_s2_ready = !r_s2_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign in_ready   = w_s1_ready;

  assign w_in_fire  = in_valid && w_s1_ready;
  assign w_s1_to_s2 = r_s1_valid && w_s2_ready;
  assign w_out_fire = r_s2_valid && out_ready;

  assign w_sum     = r_s1_a + r_s1_b;
  assign w_diff    = r_s1_a - r_s1_b;
  assign w_a_msb   = r_s1_a[WIDTH-1];
  assign w_b_msb   = r_s1_b[WIDTH-1];
  assign w_add_ovf = (w_a_msb == w_b_msb) && (w_sum[WIDTH-1] != w_a_msb);
  assign w_sub_ovf = (w_a_msb != w_b_msb) && (w_diff[WIDTH-1] != w_a_msb);
  // The sign of a-b is wrong exactly when the subtraction overflows, so
  // flipping it by the overflow bit gives the true signed less-than.
  assign w_slt     = w_diff[WIDTH-1] ^ w_sub_ovf;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    case (r_s1_ctrl)
      OP_AND:  w_res = r_s1_a & r_s1_b;
      OP_OR:   w_res = r_s1_a | r_s1_b;
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = w_add_ovf;
      end
      OP_ADDR: w_res = w_sum;
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = w_sub_ovf;
      end
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_slt};
      OP_NOR:  w_res = ~(r_s1_a | r_s1_b);
      default: w_ill = 1'b1;
    endcase
  end

  assign w_zero = (w_res == '0);

  // Stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_ctrl  <= 4'b0000;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else begin
      if (w_s1_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_in_fire) begin
        r_s1_ctrl <= in_ctrl;
        r_s1_a    <= in_a;
        r_s1_b    <= in_b;
      end
    end
  end

  // Stage 2: contents change only when it is empty or being drained, which
  // keeps every out_* stable while out_valid is held against out_ready=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid   <= 1'b0;
      r_s2_result  <= '0;
      r_s2_zero    <= 1'b0;
      r_s2_ovf     <= 1'b0;
      r_s2_illegal <= 1'b0;
    end else begin
      if (w_s2_ready) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s1_to_s2) begin
        r_s2_result  <= w_res;
        r_s2_zero    <= w_zero;
        r_s2_ovf     <= w_ovf;
        r_s2_illegal <= w_ill;
      end
    end
  end

  // Event counters, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count  <= '0;
      r_ovf_count <= '0;
    end else if (w_out_fire) begin
      if (r_op_count != CNT_MAX) begin
        r_op_count <= r_op_count + CNT_ONE;
      end
      if (r_s2_ovf && (r_ovf_count != CNT_MAX)) begin
        r_ovf_count <= r_ovf_count + CNT_ONE;
      end
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_result  = r_s2_result;
  assign out_zero    = r_s2_zero;
  assign out_ovf     = r_s2_ovf;
  assign out_illegal = r_s2_illegal;
  assign op_count    = r_op_count;
  assign ovf_count   = r_ovf_count;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized and directed bench for alu_exec_unit with a behavioural model

module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_ctrl;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_ovf;
  logic        out_illegal;
  logic [15:0] op_count;
  logic [15:0] ovf_count;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_result;
  logic        s_out_zero;
  logic        s_out_ovf;
  logic        s_out_illegal;
  logic [1:0]  s_op_count;
  logic [1:0]  s_ovf_count;

  int n_pass  = 0;
  int n_total = 0;
  int m_ops   = 0;
  int m_ovf   = 0;
  logic [34:0] exp_q[$];

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_illegal(out_illegal),
    .op_count(op_count), .ovf_count(ovf_count)
  );

  alu_exec_unit #(.WIDTH(32), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_out_result),
    .out_zero(s_out_zero), .out_ovf(s_out_ovf), .out_illegal(s_out_illegal),
    .op_count(s_op_count), .ovf_count(s_ovf_count)
  );

  // Reference: {illegal, ovf, zero, result} from the ISA rules using 64-bit signed arithmetic.
  function automatic logic [34:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint t;
    logic [31:0] r;
    logic o;
    logic il;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 32'd0;
    o  = 1'b0;
    il = 1'b0;
    case (c)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2: begin
        t = sa + sb;
        r = t[31:0];
        o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd3:  r = a + b;
      4'd6: begin
        t = sa - sb;
        r = t[31:0];
        o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: r = ~(a | b);
      default: il = 1'b1;
    endcase
    return {il, o, (r == 32'd0), r};
  endfunction

  function automatic logic [3:0] rand_legal();
    logic [3:0] codes [7];
    codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd12};
    return codes[$urandom_range(0, 6)];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_ctrl = 4'd0; in_a = 32'd0; in_b = 32'd0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
    n_total++;
    if ({out_illegal, out_ovf, out_zero, out_result} !== 35'd0)
      $display("FAIL reset_outputs got=%h want=0", {out_illegal, out_ovf, out_zero, out_result}); else n_pass++;
    n_total++;
    if (op_count !== 16'd0 || ovf_count !== 16'd0)
      $display("FAIL reset_counters got=%0d/%0d want=0/0", op_count, ovf_count); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else n_pass++;
  endtask

  task automatic test_directed();
    logic [3:0]  tc [12];
    logic [31:0] ta [12];
    logic [31:0] tb [12];
    logic [34:0] te [12];
    tc = '{4'd2, 4'd6, 4'd7, 4'd7, 4'd3, 4'd15, 4'd0, 4'd1, 4'd12, 4'd6, 4'd7, 4'd2};
    ta = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h1234,
           32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h80000000, 32'h7FFFFFFF, 32'h80000000};
    tb = '{32'd1, 32'd5, 32'd1, 32'd1, 32'd2, 32'h5678,
           32'hFF00FF00, 32'h0F0F0000, 32'h0F0F0000, 32'd1, 32'h80000000, 32'h80000000};
    // {illegal, ovf, zero, result}
    te = '{{3'b010, 32'h80000000}, {3'b001, 32'h0}, {3'b000, 32'h1}, {3'b000, 32'h1},
           {3'b000, 32'h1}, {3'b101, 32'h0}, {3'b000, 32'hF000F000}, {3'b000, 32'hFFFFF0F0},
           {3'b000, 32'h00000F0F}, {3'b010, 32'h7FFFFFFF}, {3'b001, 32'h0}, {3'b011, 32'h0}};
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_ctrl = tc[i]; in_a = ta[i]; in_b = tb[i]; out_ready = 1'b1;
      #1;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL dir%0d_in_ready got=%b want=1", i, in_ready); else n_pass++;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL dir%0d_early_valid got=%b want=0", i, out_valid); else n_pass++;
      @(negedge clk);
      #1;
      n_total++;
      if (out_valid !== 1'b1) $display("FAIL dir%0d_latency got out_valid=%b want=1", i, out_valid); else n_pass++;
      n_total++;
      if ({out_illegal, out_ovf, out_zero, out_result} !== te[i])
        $display("FAIL dir%0d_result got=%h want=%h", i, {out_illegal, out_ovf, out_zero, out_result}, te[i]);
      else n_pass++;
      m_ops++;
      if (te[i][33]) m_ovf++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    int bubbles = 0;
    logic [34:0] e;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 12; cyc++) begin
      if (sent < 12) begin
        in_valid = 1'b1; in_ctrl = rand_legal(); in_a = $urandom; in_b = $urandom;
      end else in_valid = 1'b0;
      #1;
      if (in_valid && !in_ready) bubbles++;
      if (out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
        n_total++;
        if ({out_illegal, out_ovf, out_zero, out_result} !== e)
          $display("FAIL b2b_result%0d got=%h want=%h", got, {out_illegal, out_ovf, out_zero, out_result}, e);
        else n_pass++;
        got++; m_ops++;
        if (e[33]) m_ovf++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_alu(in_ctrl, in_a, in_b));
        sent++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_total++;
    if (bubbles !== 0) $display("FAIL b2b_in_ready_drops got=%0d want=0", bubbles); else n_pass++;
    n_total++;
    if (first !== 2 || last !== 13) $display("FAIL b2b_timing got first=%0d last=%0d want 2/13", first, last); else n_pass++;
  endtask

  task automatic test_stall();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic dropped = 1'b0;
    logic prev_stall = 1'b0;
    logic [34:0] prev = '0;
    logic [34:0] e;
    while (got < 10 && cyc < 80) begin
      out_ready = !(cyc >= 3 && cyc <= 7);
      if (sent < 10) begin
        in_valid = 1'b1; in_ctrl = rand_legal(); in_a = $urandom; in_b = $urandom;
      end else in_valid = 1'b0;
      #1;
      if (prev_stall) begin
        n_total++;
        if (out_valid !== 1'b1 || {out_illegal, out_ovf, out_zero, out_result} !== prev)
          $display("FAIL stall_stable cyc%0d got v=%b %h want v=1 %h", cyc, out_valid,
                   {out_illegal, out_ovf, out_zero, out_result}, prev);
        else n_pass++;
      end
      if (!in_ready && !dropped) begin
        dropped = 1'b1;
        n_total++;
        if (sent - got !== 2) $display("FAIL stall_held_at_drop got=%0d want=2", sent - got); else n_pass++;
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
        n_total++;
        if ({out_illegal, out_ovf, out_zero, out_result} !== e)
          $display("FAIL stall_order%0d got=%h want=%h", got, {out_illegal, out_ovf, out_zero, out_result}, e);
        else n_pass++;
        got++; m_ops++;
        if (e[33]) m_ovf++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_alu(in_ctrl, in_a, in_b));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev = {out_illegal, out_ovf, out_zero, out_result};
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    n_total++;
    if (dropped !== 1'b1) $display("FAIL stall_in_ready_drop got=0 want=1"); else n_pass++;
    n_total++;
    if (got !== 10) $display("FAIL stall_delivered got=%0d want=10", got); else n_pass++;
    n_total++;
    if (op_count !== 16'(m_ops) || ovf_count !== 16'(m_ovf))
      $display("FAIL stall_counters got=%0d/%0d want=%0d/%0d", op_count, ovf_count, m_ops, m_ovf);
    else n_pass++;
  endtask

  task automatic test_random();
    int sent = 0;
    int got = 0;
    int errs = 0;
    int unstable = 0;
    logic pend = 1'b0;
    logic prev_stall = 1'b0;
    logic [34:0] prev = '0;
    logic [34:0] e;
    for (int cyc = 0; cyc < 3000 && (got < 300 || sent < 300); cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        if (sent < 300 && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1; in_ctrl = 4'($urandom_range(0, 15)); in_a = $urandom; in_b = $urandom;
        end else in_valid = 1'b0;
      end
      #1;
      if (prev_stall && (out_valid !== 1'b1 || {out_illegal, out_ovf, out_zero, out_result} !== prev))
        unstable++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL rand_spurious_output got=%h want=none", out_result);
        end else begin
          e = exp_q.pop_front();
          if ({out_illegal, out_ovf, out_zero, out_result} !== e) begin
            errs++;
            $display("FAIL rand_result%0d got=%h want=%h", got, {out_illegal, out_ovf, out_zero, out_result}, e);
          end
          if (e[33]) m_ovf++;
        end
        got++; m_ops++;
      end
      pend = in_valid && !in_ready;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_alu(in_ctrl, in_a, in_b));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev = {out_illegal, out_ovf, out_zero, out_result};
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_total++;
    if (errs !== 0) $display("FAIL rand_results got=%0d errors want=0", errs); else n_pass++;
    n_total++;
    if (unstable !== 0) $display("FAIL rand_stall_stable got=%0d want=0", unstable); else n_pass++;
    n_total++;
    if (got !== 300 || exp_q.size() !== 0)
      $display("FAIL rand_delivered got=%0d left=%0d want=300/0", got, exp_q.size()); else n_pass++;
    n_total++;
    if (op_count !== 16'(m_ops) || ovf_count !== 16'(m_ovf))
      $display("FAIL rand_counters got=%0d/%0d want=%0d/%0d", op_count, ovf_count, m_ops, m_ovf);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int stale = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ctrl = 4'd2; in_a = 32'h7FFFFFFF; in_b = 32'd1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL areset_full got v=%b rdy=%b want 1/0", out_valid, in_ready); else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || out_result !== 32'd0 || in_ready !== 1'b1)
      $display("FAIL areset_immediate got v=%b res=%h rdy=%b want 0/0/1", out_valid, out_result, in_ready);
    else n_pass++;
    exp_q.delete();
    m_ops = 0; m_ovf = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (out_valid !== 1'b0) stale++;
      @(negedge clk);
    end
    n_total++;
    if (stale !== 0) $display("FAIL areset_stale got=%0d want=0", stale); else n_pass++;
    n_total++;
    if (op_count !== 16'd0 || ovf_count !== 16'd0)
      $display("FAIL areset_counters got=%0d/%0d want=0/0", op_count, ovf_count); else n_pass++;
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_ctrl = 4'd2; in_a = 32'h7FFFFFFF; in_b = 32'd1 + 32'(i);
      @(negedge clk);
      m_ops++; m_ovf++;
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_total++;
    if (s_op_count !== 2'd3 || s_ovf_count !== 2'd3)
      $display("FAIL sat_small got=%0d/%0d want=3/3", s_op_count, s_ovf_count); else n_pass++;
    n_total++;
    if (op_count !== 16'(m_ops) || ovf_count !== 16'(m_ovf))
      $display("FAIL sat_wide got=%0d/%0d want=%0d/%0d", op_count, ovf_count, m_ops, m_ovf); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random();
    test_async_reset();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
